// File: rtl/hyper_ckseq_pkg.sv
// Shared state encoding and default timing for the HyperBus CK/CS sequencer.
package hyper_ckseq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_RUN,
    ST_HOLD,
    ST_RECOVER
  } ckseq_state_e;

  localparam int DEF_CNT_W    = 16;
  localparam int DEF_CS_SETUP = 2;
  localparam int DEF_CS_HOLD  = 2;
  localparam int DEF_CS_IDLE  = 3;
  localparam int DEF_CS_MAX   = 400;

  // Width of the shared SETUP/HOLD/RECOVER phase counter.
  localparam int PH_W  = 8;
  // Width of the CS-low cycle counter (saturating).
  localparam int CSL_W = 16;

endpackage

// File: rtl/hyper_ck_sequencer.sv
// HyperBus CK-enable / chip-select sequencer: SETUP -> RUN -> HOLD -> RECOVER per burst.
// Optional CS-low time limit enabled by defining HYPER_CKSEQ_CSMAX_EN.
//
// state    | meaning
// IDLE     | CS high, waiting for a request handshake
// SETUP    | selected CS low, CK gated off for CS_SETUP cycles
// RUN      | CS low, CK enabled on every unstalled cycle until len periods issued
// HOLD     | CS low, CK gated off for CS_HOLD cycles
// RECOVER  | CS high for CS_IDLE cycles; done pulse in the first cycle
module hyper_ck_sequencer
  import hyper_ckseq_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int CS_SETUP = DEF_CS_SETUP,
  parameter int CS_HOLD  = DEF_CS_HOLD,
  parameter int CS_IDLE  = DEF_CS_IDLE,
  parameter int CS_MAX   = DEF_CS_MAX
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [CNT_W-1:0] req_len_i,
  input  logic             req_cs_sel_i,
  input  logic             stall_i,
  output logic             ck_en_o,
  output logic [1:0]       cs_no,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] done_len_o,
  output logic             done_trunc_o
);

  ckseq_state_e     state_q;
  logic [PH_W-1:0]  phase_q;
  logic [CNT_W-1:0] rem_q;
  logic [CNT_W-1:0] iss_q;
  logic [1:0]       cs_n_q;
  logic             ck_en_q;
  logic             done_q;
  logic [CNT_W-1:0] done_len_q;
  logic             trunc_now;
  logic             issue_en;

`ifdef HYPER_CKSEQ_CSMAX_EN
  logic [CSL_W-1:0] csl_q;
  logic             trunc_q;
  logic             done_trunc_q;

  // Cut RUN early so that HOLD still fits inside the CS_MAX window.
  assign trunc_now    = (state_q == ST_RUN) && (rem_q != '0) &&
                        (csl_q >= CSL_W'(CS_MAX - CS_HOLD));
  assign done_trunc_o = done_trunc_q;
`else
  assign trunc_now    = 1'b0;
  assign done_trunc_o = 1'b0;
`endif

  assign req_ready_o = (state_q == ST_IDLE) && !rst_i;
  assign busy_o      = (state_q != ST_IDLE);
  assign ck_en_o     = ck_en_q;
  assign cs_no       = cs_n_q;
  assign done_o      = done_q;
  assign done_len_o  = done_len_q;

  // A CK period is issued in the cycle following an edge that sees no stall.
  assign issue_en = !stall_i &&
                    (((state_q == ST_SETUP) && (phase_q == '0)) ||
                     ((state_q == ST_RUN) && (rem_q != '0) && !trunc_now));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      phase_q    <= '0;
      rem_q      <= '0;
      iss_q      <= '0;
      cs_n_q     <= 2'b11;
      ck_en_q    <= 1'b0;
      done_q     <= 1'b0;
      done_len_q <= '0;
`ifdef HYPER_CKSEQ_CSMAX_EN
      csl_q        <= '0;
      trunc_q      <= 1'b0;
      done_trunc_q <= 1'b0;
`endif
    end else begin
      done_q  <= 1'b0;
      ck_en_q <= 1'b0;

      if (issue_en) begin
        ck_en_q <= 1'b1;
        rem_q   <= rem_q - CNT_W'(1);
        iss_q   <= iss_q + CNT_W'(1);
      end

`ifdef HYPER_CKSEQ_CSMAX_EN
      if ((cs_n_q != 2'b11) && (csl_q != '1)) begin
        csl_q <= csl_q + CSL_W'(1);
      end
`endif

      unique case (state_q)
        ST_IDLE: begin
          if (req_valid_i) begin
            rem_q   <= (req_len_i == '0) ? CNT_W'(1) : req_len_i;
            iss_q   <= '0;
            cs_n_q  <= req_cs_sel_i ? 2'b01 : 2'b10;
            phase_q <= PH_W'(CS_SETUP - 1);
            state_q <= ST_SETUP;
`ifdef HYPER_CKSEQ_CSMAX_EN
            csl_q   <= CSL_W'(1);
            trunc_q <= 1'b0;
`endif
          end
        end
        ST_SETUP: begin
          if (phase_q == '0) begin
            state_q <= ST_RUN;
          end else begin
            phase_q <= phase_q - PH_W'(1);
          end
        end
        ST_RUN: begin
          if ((rem_q == '0) || trunc_now) begin
            state_q <= ST_HOLD;
            phase_q <= PH_W'(CS_HOLD - 1);
`ifdef HYPER_CKSEQ_CSMAX_EN
            trunc_q <= trunc_now;
`endif
          end
        end
        ST_HOLD: begin
          if (phase_q == '0) begin
            state_q    <= ST_RECOVER;
            phase_q    <= PH_W'(CS_IDLE - 1);
            cs_n_q     <= 2'b11;
            done_q     <= 1'b1;
            done_len_q <= iss_q;
`ifdef HYPER_CKSEQ_CSMAX_EN
            done_trunc_q <= trunc_q;
`endif
          end else begin
            phase_q <= phase_q - PH_W'(1);
          end
        end
        ST_RECOVER: begin
          if (phase_q == '0) begin
            state_q <= ST_IDLE;
          end else begin
            phase_q <= phase_q - PH_W'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cs_n_q  <= 2'b11;
        end
      endcase
    end
  end

endmodule
